// File: rtl/nexys_starship_top_defender_if.sv
// Signal bundle between the defender, the fire-button/play logic and the top-lane spawner.
// The master side drives the game inputs; the slave side is the defender itself.
interface nexys_starship_top_defender_if #(
    parameter int unsigned SCORE_W = 8
);
    logic               play_flag;
    logic               monster_present;
    logic               btn_fire;
    logic               monster_kill;
    logic               shot_active;
    logic [SCORE_W-1:0] score;
    logic               game_over;
    logic [5:0]         state;

    modport master (
        output play_flag,
        output monster_present,
        output btn_fire,
        input  monster_kill,
        input  shot_active,
        input  score,
        input  game_over,
        input  state
    );

    modport slave (
        input  play_flag,
        input  monster_present,
        input  btn_fire,
        output monster_kill,
        output shot_active,
        output score,
        output game_over,
        output state
    );
endinterface

// File: rtl/nexys_starship_top_defender.sv
// Top-lane defender: fires timed shots at the spawner's monster, pulses monster_kill on a hit,
// keeps a saturating hit score and latches game over when a monster outlives the threat timer.
module nexys_starship_top_defender #(
    parameter int unsigned SHOT_CYCLES     = 4,
    parameter int unsigned COOLDOWN_CYCLES = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 1000,
    parameter int unsigned SCORE_W         = 8,
    parameter int unsigned TIMER_W         = 16
) (
    input  logic                           Clk,
    input  logic                           Reset,
    nexys_starship_top_defender_if.slave   bus
);

    typedef enum logic [5:0] {
        StIdle     = 6'b000001,
        StWait     = 6'b000010,
        StEngaged  = 6'b000100,
        StFiring   = 6'b001000,
        StCooldown = 6'b010000,
        StOver     = 6'b100000
    } state_e;

    localparam logic [TIMER_W-1:0] TimerOne   = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] ShotLast   = TIMER_W'(SHOT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] CoolLast   = TIMER_W'(COOLDOWN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] ThreatLast = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SCORE_W-1:0] ScoreMax   = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] ScoreOne   = SCORE_W'(1);

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] threat_q, threat_d;
    logic [TIMER_W-1:0] shot_q, shot_d;
    logic [TIMER_W-1:0] cd_q, cd_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               kill_q, kill_d;

    // The spawner may still show the monster on the kill cycle; it is ignored then.
    logic present_eff;
    logic timeout;

    assign present_eff = bus.monster_present & ~kill_q;
    assign timeout     = (threat_q == ThreatLast) & present_eff;

    always_comb begin
        state_d  = state_q;
        threat_d = threat_q;
        shot_d   = shot_q;
        cd_d     = cd_q;
        score_d  = score_q;
        kill_d   = 1'b0;

        if (!bus.play_flag && state_q != StOver) begin
            state_d  = StIdle;
            threat_d = '0;
            shot_d   = '0;
            cd_d     = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    threat_d = '0;
                    shot_d   = '0;
                    cd_d     = '0;
                    state_d  = StWait;
                end

                StWait: begin
                    threat_d = '0;
                    if (bus.monster_present) begin
                        state_d = StEngaged;
                    end else if (bus.btn_fire) begin
                        state_d = StCooldown;
                        cd_d    = '0;
                    end
                end

                StEngaged: begin
                    if (!bus.monster_present) begin
                        state_d  = StWait;
                        threat_d = '0;
                    end else if (timeout) begin
                        state_d = StOver;
                    end else begin
                        threat_d = threat_q + TimerOne;
                        if (bus.btn_fire) begin
                            state_d = StFiring;
                            shot_d  = '0;
                        end
                    end
                end

                StFiring: begin
                    threat_d = threat_q + TimerOne;
                    // Hit resolution takes priority over a coincident timeout.
                    if (shot_q == ShotLast) begin
                        state_d = StCooldown;
                        cd_d    = '0;
                        if (bus.monster_present) begin
                            kill_d   = 1'b1;
                            threat_d = '0;
                            score_d  = (score_q == ScoreMax) ? score_q : score_q + ScoreOne;
                        end
                    end else if (timeout) begin
                        state_d = StOver;
                    end else begin
                        shot_d = shot_q + TimerOne;
                    end
                end

                StCooldown: begin
                    if (present_eff) begin
                        threat_d = threat_q + TimerOne;
                    end
                    if (timeout) begin
                        state_d = StOver;
                    end else if (cd_q == CoolLast) begin
                        state_d = present_eff ? StEngaged : StWait;
                    end else begin
                        cd_d = cd_q + TimerOne;
                    end
                end

                StOver: begin
                    state_d = StOver;
                end

                default: begin
                    state_d  = StIdle;
                    threat_d = '0;
                    shot_d   = '0;
                    cd_d     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= StIdle;
            threat_q <= '0;
            shot_q   <= '0;
            cd_q     <= '0;
            score_q  <= '0;
            kill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            threat_q <= threat_d;
            shot_q   <= shot_d;
            cd_q     <= cd_d;
            score_q  <= score_d;
            kill_q   <= kill_d;
        end
    end

    assign bus.monster_kill = kill_q;
    assign bus.shot_active  = (state_q == StFiring);
    assign bus.game_over    = (state_q == StOver);
    assign bus.score        = score_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_nexys_starship_top_defender.sv
// Self-checking bench for the top-lane defender: kill pulses are scored against a queue of
// expected (cycle, score) entries pushed when each hitting shot is fired.
`timescale 1ns/1ps
module tb_nexys_starship_top_defender;

    localparam int unsigned Shot    = 4;
    localparam int unsigned Cool    = 8;
    localparam int unsigned Timeout = 20;
    localparam int unsigned ScoreW  = 8;

    localparam logic [5:0] StIdle     = 6'b000001;
    localparam logic [5:0] StWait     = 6'b000010;
    localparam logic [5:0] StEngaged  = 6'b000100;
    localparam logic [5:0] StFiring   = 6'b001000;
    localparam logic [5:0] StCooldown = 6'b010000;
    localparam logic [5:0] StOver     = 6'b100000;

    typedef struct {
        int unsigned cyc;
        int unsigned score;
    } exp_t;

    logic Clk;
    logic Reset;
    int unsigned cyc;
    int unsigned n_checks;
    int unsigned n_errors;
    int unsigned exp_score;
    exp_t sb[$];

    nexys_starship_top_defender_if #(.SCORE_W(ScoreW)) bus ();

    nexys_starship_top_defender #(
        .SHOT_CYCLES    (Shot),
        .COOLDOWN_CYCLES(Cool),
        .TIMEOUT_CYCLES (Timeout),
        .SCORE_W        (ScoreW),
        .TIMER_W        (16)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard: every kill pulse must match the oldest expected hit.
    always @(negedge Clk) begin
        if (!Reset && bus.monster_kill === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("kill_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("kill_cycle", cyc, e.cyc);
                check_eq("kill_score", 32'(bus.score), e.score);
            end
        end
    end

    // One cycle; fire is a single-cycle pulse and the spawner clears on a kill.
    task automatic step();
        @(posedge Clk);
        #1;
        bus.btn_fire = 1'b0;
        if (bus.monster_kill === 1'b1) bus.monster_present = 1'b0;
    endtask

    task automatic fire(input bit hit);
        if (hit) begin
            exp_t e;
            exp_score = (exp_score == 255) ? 255 : exp_score + 1;
            e.cyc   = cyc + 1 + Shot;
            e.score = exp_score;
            sb.push_back(e);
        end
        bus.btn_fire = 1'b1;
        step();
    endtask

    task automatic wait_state(input string tag, input logic [5:0] want, input int budget);
        int n;
        n = 0;
        while (bus.state !== want && n < budget) begin
            step();
            n++;
        end
        check_eq(tag, 32'(bus.state), 32'(want));
    endtask

    task automatic do_reset(input string tag);
        Reset               = 1'b1;
        bus.play_flag       = 1'b0;
        bus.monster_present = 1'b0;
        bus.btn_fire        = 1'b0;
        exp_score           = 0;
        step();
        check_eq({tag, "_state"}, 32'(bus.state), 32'(StIdle));
        check_eq({tag, "_kill"}, 32'(bus.monster_kill), 32'd0);
        check_eq({tag, "_shot"}, 32'(bus.shot_active), 32'd0);
        check_eq({tag, "_score"}, 32'(bus.score), 32'd0);
        check_eq({tag, "_over"}, 32'(bus.game_over), 32'd0);
        Reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_score = 0;
        cyc = 0;
        Reset = 1'b1;
        bus.play_flag = 1'b0;
        bus.monster_present = 1'b0;
        bus.btn_fire = 1'b0;
        step();
        do_reset("rst");

        // Basic hit: kill exactly 1+Shot cycles after the fire cycle.
        bus.play_flag = 1'b1;
        step();
        check_eq("s1_wait", 32'(bus.state), 32'(StWait));
        bus.monster_present = 1'b1;
        step();
        check_eq("s1_engaged", 32'(bus.state), 32'(StEngaged));
        step();
        fire(1);
        check_eq("s1_firing", 32'(bus.state), 32'(StFiring));
        check_eq("s1_shot", 32'(bus.shot_active), 32'd1);
        wait_state("s1_cd", StCooldown, 10);
        step();
        check_eq("s1_kill_once", 32'(bus.monster_kill), 32'd0);
        wait_state("s1_back", StWait, 20);
        check_eq("s1_score", 32'(bus.score), exp_score);

        // Wasted shot in WAIT: full cooldown, no score.
        fire(0);
        check_eq("s3_cd", 32'(bus.state), 32'(StCooldown));
        repeat (Cool - 1) step();
        check_eq("s3_cd_end", 32'(bus.state), 32'(StCooldown));
        step();
        check_eq("s3_wait", 32'(bus.state), 32'(StWait));
        check_eq("s3_score", 32'(bus.score), exp_score);

        // Extra fire pulses during FIRING and COOLDOWN are ignored.
        bus.monster_present = 1'b1;
        step();
        fire(1);
        repeat (3) fire(0);
        repeat (4) fire(0);
        wait_state("s3_ign_wait", StWait, 20);
        check_eq("s3_ign_score", 32'(bus.score), exp_score);

        // Monster leaves mid-shot: miss, no kill.
        bus.monster_present = 1'b1;
        step();
        fire(0);
        step();
        bus.monster_present = 1'b0;
        wait_state("s4_cd", StCooldown, 10);
        wait_state("s4_wait", StWait, 20);
        check_eq("s4_score", 32'(bus.score), exp_score);

        // Hit resolving on the timeout cycle wins.
        bus.monster_present = 1'b1;
        step();
        repeat (15) step();
        fire(1);
        wait_state("s4_to_cd", StCooldown, 10);
        check_eq("s4_to_over", 32'(bus.game_over), 32'd0);
        wait_state("s4_to_wait", StWait, 20);
        check_eq("s4_to_over2", 32'(bus.game_over), 32'd0);

        // Threat timeout: game over exactly Timeout cycles after ENGAGED entry.
        bus.monster_present = 1'b1;
        step();
        repeat (Timeout - 1) step();
        check_eq("s2_pre_state", 32'(bus.state), 32'(StEngaged));
        check_eq("s2_pre_over", 32'(bus.game_over), 32'd0);
        step();
        check_eq("s2_over", 32'(bus.game_over), 32'd1);
        check_eq("s2_state", 32'(bus.state), 32'(StOver));
        bus.play_flag = 1'b0;
        bus.monster_present = 1'b0;
        fire(0);
        repeat (3) step();
        check_eq("s2_sticky", 32'(bus.game_over), 32'd1);
        check_eq("s2_sticky_state", 32'(bus.state), 32'(StOver));
        check_eq("s2_frozen_score", 32'(bus.score), exp_score);
        check_eq("s2_no_shot", 32'(bus.shot_active), 32'd0);
        do_reset("rst_over");

        // Score saturation over 256 hits.
        bus.play_flag = 1'b1;
        step();
        for (int i = 0; i < 256; i++) begin
            bus.monster_present = 1'b1;
            step();
            fire(1);
            wait_state("sat_wait", StWait, 30);
        end
        check_eq("sat_score", 32'(bus.score), 32'd255);

        // Reset in the middle of a shot.
        bus.monster_present = 1'b1;
        step();
        fire(0);
        step();
        check_eq("rf_firing", 32'(bus.state), 32'(StFiring));
        do_reset("rst_fire");

        // play_flag low in ENGAGED returns to IDLE with score held.
        bus.play_flag = 1'b1;
        step();
        bus.monster_present = 1'b1;
        step();
        fire(1);
        wait_state("pf_wait", StWait, 30);
        bus.monster_present = 1'b1;
        step();
        check_eq("pf_engaged", 32'(bus.state), 32'(StEngaged));
        bus.play_flag = 1'b0;
        step();
        check_eq("pf_idle", 32'(bus.state), 32'(StIdle));
        check_eq("pf_score", 32'(bus.score), 32'd1);
        check_eq("pf_kill", 32'(bus.monster_kill), 32'd0);
        bus.monster_present = 1'b0;
        repeat (2) step();

        check_eq("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
